// File: rtl/pad_mux_ctrl.sv
// Pad multiplexer controller.
// It services read and write requests for the per-pad mux select values.
// When a write changes a select, the pad's output enable is held off before
// and after the switch so that the pad never drives while its mux is moving.
// Each pad has a lock bit that blocks later writes to it until the next reset.
module pad_mux_ctrl #(
    parameter  int NUM_PAD      = 14,
    parameter  int SEL_W        = 2,
    parameter  int GUARD_CYCLES = 3,
    localparam int PAD_IDX_W    = (NUM_PAD > 1) ? $clog2(NUM_PAD) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_write_i,
    input  logic                            req_lock_i,
    input  logic [PAD_IDX_W-1:0]            req_pad_i,
    input  logic [SEL_W-1:0]                req_sel_i,
    output logic                            rsp_valid_o,
    output logic [SEL_W-1:0]                rsp_sel_o,
    output logic                            rsp_err_o,
    output logic [NUM_PAD-1:0][SEL_W-1:0]   pad_muxes_o,
    output logic [NUM_PAD-1:0]              pad_oe_gate_o,
    output logic                            busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_APPLY  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // One extra bit so that an index equal to NUM_PAD can be recognised as out of range.
    localparam logic [PAD_IDX_W:0] NUM_PAD_L   = (PAD_IDX_W + 1)'(NUM_PAD);
    // The guard counter counts down to zero, so it is loaded with the cycle count minus one.
    localparam logic [3:0]         GATE_LOAD   = 4'(GUARD_CYCLES - 1);
    localparam logic [3:0]         SETTLE_LOAD = (GUARD_CYCLES > 1) ? 4'(GUARD_CYCLES - 2) : 4'd0;
    // With a one-cycle guard there are no SETTLE cycles, so APPLY goes straight to RESP.
    localparam bit                 NO_SETTLE   = (GUARD_CYCLES == 1);

    state_t                         state_q, state_d;
    logic [3:0]                     cnt_q, cnt_d;
    logic [NUM_PAD-1:0][SEL_W-1:0]  mux_q, mux_d;
    logic [NUM_PAD-1:0]             gate_q, gate_d;
    logic [NUM_PAD-1:0]             lock_q, lock_d;
    logic [PAD_IDX_W-1:0]           pad_q, pad_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic                           lreq_q, lreq_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [SEL_W-1:0]               rsp_sel_q, rsp_sel_d;
    logic                           rsp_err_q, rsp_err_d;

    logic                           in_range_s;
    logic [SEL_W-1:0]               cur_sel_s;

    assign in_range_s = ({1'b0, req_pad_i} < NUM_PAD_L);
    // Only meaningful when in_range_s is set; every use below is guarded by it.
    assign cur_sel_s  = mux_q[req_pad_i];

    // State register and all datapath registers, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            mux_q       <= '0;
            gate_q      <= '1;
            lock_q      <= '0;
            pad_q       <= '0;
            sel_q       <= '0;
            lreq_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sel_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mux_q       <= mux_d;
            gate_q      <= gate_d;
            lock_q      <= lock_d;
            pad_q       <= pad_d;
            sel_q       <= sel_d;
            lreq_q      <= lreq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and datapath update for the request / gate / apply / settle sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mux_d       = mux_q;
        gate_d      = gate_q;
        lock_d      = lock_q;
        pad_d       = pad_q;
        sel_d       = sel_q;
        lreq_d      = lreq_q;
        rsp_valid_d = 1'b0;
        rsp_sel_d   = rsp_sel_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (!in_range_s) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_sel_d   = {SEL_W{1'b0}};
                    end else if (!req_write_i) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_sel_d   = cur_sel_s;
                    end else if (lock_q[req_pad_i]) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_sel_d   = {SEL_W{1'b0}};
                    end else if (req_sel_i == cur_sel_s) begin
                        // Nothing moves, so no guard is needed; the lock still applies.
                        state_d           = ST_RESP;
                        rsp_valid_d       = 1'b1;
                        rsp_err_d         = 1'b0;
                        rsp_sel_d         = cur_sel_s;
                        lock_d[req_pad_i] = lock_q[req_pad_i] | req_lock_i;
                    end else begin
                        state_d           = ST_GATE;
                        pad_d             = req_pad_i;
                        sel_d             = req_sel_i;
                        lreq_d            = req_lock_i;
                        gate_d[req_pad_i] = 1'b0;
                        cnt_d             = GATE_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_APPLY: begin
                mux_d[pad_q] = sel_q;
                if (NO_SETTLE) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_sel_d     = sel_q;
                    gate_d[pad_q] = 1'b1;
                    lock_d[pad_q] = lock_q[pad_q] | lreq_q;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_sel_d     = sel_q;
                    gate_d[pad_q] = 1'b1;
                    lock_d[pad_q] = lock_q[pad_q] | lreq_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_sel_o     = rsp_sel_q;
    assign rsp_err_o     = rsp_err_q;
    assign pad_muxes_o   = mux_q;
    assign pad_oe_gate_o = gate_q;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl.
// Directed scenarios are followed by randomized requests. The expected outputs
// come from a per-pad model of selects and lock bits, plus the cycle timing
// that a request is supposed to follow.
module tb_pad_mux_ctrl;

    localparam int NP = 14;
    localparam int SW = 2;
    localparam int G  = 3;
    localparam int PW = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic                  req_lock_i;
    logic [PW-1:0]         req_pad_i;
    logic [SW-1:0]         req_sel_i;
    logic                  rsp_valid_o;
    logic [SW-1:0]         rsp_sel_o;
    logic                  rsp_err_o;
    logic [NP-1:0][SW-1:0] pad_muxes_o;
    logic [NP-1:0]         pad_oe_gate_o;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;
    int msel [NP];
    bit mlock[NP];

    pad_mux_ctrl #(.NUM_PAD(NP), .SEL_W(SW), .GUARD_CYCLES(G)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_lock_i   (req_lock_i),
        .req_pad_i    (req_pad_i),
        .req_sel_i    (req_sel_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_sel_o    (rsp_sel_o),
        .rsp_err_o    (rsp_err_o),
        .pad_muxes_o  (pad_muxes_o),
        .pad_oe_gate_o(pad_oe_gate_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Safety net in case the run ever stops making progress.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Expected mux vector: the model selects, with one pad optionally overridden.
    function automatic logic [NP*SW-1:0] mux_vec(int pad, int val);
        logic [NP*SW-1:0] v;
        for (int i = 0; i < NP; i++) begin
            v[i*SW +: SW] = (i == pad) ? SW'(val) : SW'(msel[i]);
        end
        return v;
    endfunction

    // Expected gate vector: all pads permitted except an optional gated pad.
    function automatic logic [NP-1:0] gate_vec(int pad);
        logic [NP-1:0] v;
        for (int i = 0; i < NP; i++) begin
            v[i] = (i != pad);
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_inputs(bit valid);
        req_valid_i = valid;
        req_write_i = 1'($urandom_range(0, 1));
        req_lock_i  = 1'($urandom_range(0, 1));
        req_pad_i   = PW'($urandom_range(0, 15));
        req_sel_i   = SW'($urandom_range(0, 3));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            msel[i]  = 0;
            mlock[i] = 1'b0;
        end
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_mux"},   64'(pad_muxes_o),   64'(0));
        chk({tag, "_gate"},  64'(pad_oe_gate_o), 64'(gate_vec(-1)));
        chk({tag, "_ready"}, 64'(req_ready_o),   64'(1));
        chk({tag, "_rspv"},  64'(rsp_valid_o),   64'(0));
        chk({tag, "_busy"},  64'(busy_o),        64'(0));
    endtask

    // Issue one request and follow it cycle by cycle until its response.
    // When abort_k > 0, reset is raised in cycle abort_k and the response is not awaited.
    task automatic do_req(bit wr, bit lk, int pad, int sel, bit noisy, int abort_k);
        bit inr, err, sw;
        int cur, rsel, len;
        @(negedge clk_i);
        chk("ready_pre", 64'(req_ready_o), 64'(1));
        chk("busy_pre",  64'(busy_o),      64'(0));
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_lock_i  = lk;
        req_pad_i   = PW'(pad);
        req_sel_i   = SW'(sel);
        @(posedge clk_i);
        #1;
        if (noisy) randomize_inputs(1'b1);
        else       req_valid_i = 1'b0;

        inr  = (pad < NP);
        cur  = inr ? msel[pad] : 0;
        err  = !inr || (wr && mlock[pad]);
        sw   = inr && wr && !mlock[pad] && (sel != cur);
        rsel = err ? 0 : (sw ? sel : cur);
        len  = sw ? 2*G + 1 : 1;

        for (int k = 1; k <= len; k++) begin
            @(negedge clk_i);
            chk("mux",   64'(pad_muxes_o),
                64'((sw && k >= G + 2) ? mux_vec(pad, sel) : mux_vec(-1, 0)));
            chk("gate",  64'(pad_oe_gate_o), 64'((sw && k <= 2*G) ? gate_vec(pad) : gate_vec(-1)));
            chk("busy",  64'(busy_o),      64'(1));
            chk("ready", 64'(req_ready_o), 64'(0));
            chk("rspv",  64'(rsp_valid_o), 64'(k == len));
            if (k == len) begin
                chk("rsp_sel", 64'(rsp_sel_o), 64'(rsel));
                chk("rsp_err", 64'(rsp_err_o), 64'(err));
            end
            if (abort_k == k) begin
                rst_i       = 1'b1;
                req_valid_i = 1'b0;
                @(negedge clk_i);
                rst_i = 1'b0;
                model_reset();
                check_reset_state("abort");
                return;
            end
            if (k == len) req_valid_i = 1'b0;
            else if (noisy) randomize_inputs(1'b1);
        end

        if (sw) msel[pad] = sel;
        if (inr && wr && !err && lk) mlock[pad] = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1;
        randomize_inputs(1'b0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_state("reset");

        do_req(1'b1, 1'b0, 4, 2, 1'b0, 0);          // switching write with guard
        do_req(1'b1, 1'b0, 4, 2, 1'b0, 0);          // same select: immediate response
        do_req(1'b0, 1'b0, 4, 0, 1'b0, 0);          // read back
        do_req(1'b1, 1'b0, 14, 1, 1'b0, 0);         // out-of-range pad
        do_req(1'b1, 1'b1, 1, 3, 1'b0, 0);          // write and lock
        do_req(1'b1, 1'b0, 1, 0, 1'b0, 0);          // rejected by lock
        do_req(1'b0, 1'b0, 1, 0, 1'b0, 0);          // locked pad still reads 3
        do_req(1'b1, 1'b0, 6, 1, 1'b0, G + 3);      // reset in second SETTLE cycle
        do_req(1'b1, 1'b0, 1, 2, 1'b0, 0);          // lock gone after reset
        do_req(1'b1, 1'b0, 13, 3, 1'b1, 0);         // requests while busy are ignored

        for (int n = 0; n < 80; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk_i);
            do_req(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
